// File: rtl/stochastic_output_counter.sv
// -----------------------------------------------------------------------------
// stochastic_output_counter
//
// Counts the ones in the x and y stochastic streams of each output column.
// The last kernel row delivers one bit pair per (column, bit position). When
// a column's final bit position arrives, the completed pair of counts is
// queued in a small FIFO for a downstream consumer to drain.
//
// Ports
//   clock        single clock; all state changes on the rising edge
//   reset        synchronous active-low reset
//   enable       current bit pair is valid this cycle
//   final_val_x  x stochastic bit for the current (column, bit position)
//   final_val_y  y stochastic bit for the current (column, bit position)
//   width_index  input-image column index
//   sc_count     bit position within the stochastic stream
//   out_valid    out_col / out_count_x / out_count_y hold a completed result
//   out_ready    consumer accepts the result this cycle
//   out_col      output column of the head result
//   out_count_x  number of ones in the x stream of the head result
//   out_count_y  number of ones in the y stream of the head result
//   overflow     sticky: a completed result was dropped on a full FIFO
//
// Handshake: a result transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the head outputs
// hold stable. out_valid never depends on out_ready.
//
// The sizing parameters are shared with the rest of the datapath; the values
// below are placeholders that the system configuration overrides.
// -----------------------------------------------------------------------------
module stochastic_output_counter #(
  parameter int SC_LEN          = 8,
  parameter int SC_LEN_LOG      = 3,
  parameter int INPUT_WIDTH     = 8,
  parameter int INPUT_WIDTH_LOG = 3,
  parameter int KERNEL_WIDTH    = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       final_val_x,
  input  logic                       final_val_y,
  input  logic [INPUT_WIDTH_LOG-1:0] width_index,
  input  logic [SC_LEN_LOG-1:0]      sc_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_WIDTH_LOG-1:0] out_col,
  output logic [SC_LEN_LOG:0]        out_count_x,
  output logic [SC_LEN_LOG:0]        out_count_y,
  output logic                       overflow
);

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int NUM_COLS   = INPUT_WIDTH - (KERNEL_WIDTH - 1);
  localparam int CNT_W      = SC_LEN_LOG + 1;
  localparam int COL_W      = INPUT_WIDTH_LOG;

  // Per-column counters
  logic [CNT_W-1:0] count_x_q [NUM_COLS];
  logic [CNT_W-1:0] count_x_d [NUM_COLS];
  logic [CNT_W-1:0] count_y_q [NUM_COLS];
  logic [CNT_W-1:0] count_y_d [NUM_COLS];

  // Result FIFO
  logic [COL_W-1:0] mem_col_q [FIFO_DEPTH];
  logic [COL_W-1:0] mem_col_d [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_x_q   [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_x_d   [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_y_q   [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_y_d   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             overflow_q, overflow_d;

  logic             col_ok;
  logic [COL_W-1:0] col_idx;
  logic [CNT_W-1:0] new_x, new_y;
  logic             push, pop, full, do_write;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so a non-power-of-two depth still cycles correctly.
    if (p == PTR_W'(FIFO_DEPTH - 1)) ptr_inc = '0;
    else                             ptr_inc = p + 1'b1;
  endfunction

  // Columns left of the first full kernel window (and beyond the image)
  // carry no output column and are ignored entirely.
  always_comb begin
    col_ok  = enable && (int'(width_index) >= KERNEL_WIDTH - 1)
                     && (int'(width_index) <  INPUT_WIDTH);
    col_idx = col_ok ? (width_index - COL_W'(KERNEL_WIDTH - 1)) : '0;
  end

  // Bit position 0 restarts the count; later positions accumulate.
  always_comb begin
    if (sc_count == '0) begin
      new_x = CNT_W'(final_val_x);
      new_y = CNT_W'(final_val_y);
    end else begin
      new_x = count_x_q[col_idx] + CNT_W'(final_val_x);
      new_y = count_y_q[col_idx] + CNT_W'(final_val_y);
    end
  end

  assign push     = col_ok && (sc_count == SC_LEN_LOG'(SC_LEN - 1));
  assign full     = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop      = out_valid && out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO still
  // accepts a push when the consumer takes a result.
  assign do_write = push && (!full || pop);

  always_comb begin
    count_x_d  = count_x_q;
    count_y_d  = count_y_q;
    mem_col_d  = mem_col_q;
    mem_x_d    = mem_x_q;
    mem_y_d    = mem_y_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;

    if (col_ok) begin
      count_x_d[col_idx] = new_x;
      count_y_d[col_idx] = new_y;
    end

    if (do_write) begin
      mem_col_d[wr_ptr_q] = col_idx;
      mem_x_d[wr_ptr_q]   = new_x;
      mem_y_d[wr_ptr_q]   = new_y;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    occ_d = occ_q + OCC_W'(do_write) - OCC_W'(pop);

    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        count_x_q[i] <= '0;
        count_y_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_col_q[i] <= '0;
        mem_x_q[i]   <= '0;
        mem_y_q[i]   <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_x_q  <= count_x_d;
      count_y_q  <= count_y_d;
      mem_col_q  <= mem_col_d;
      mem_x_q    <= mem_x_d;
      mem_y_q    <= mem_y_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs read zero while reset is held, even before the first edge
  // clears the FIFO state.
  assign out_valid   = reset && (occ_q != '0);
  assign out_col     = out_valid ? mem_col_q[rd_ptr_q] : '0;
  assign out_count_x = out_valid ? mem_x_q[rd_ptr_q]   : '0;
  assign out_count_y = out_valid ? mem_y_q[rd_ptr_q]   : '0;
  assign overflow    = overflow_q;

endmodule

// File: doc/stochastic_output_counter.md
STOCHASTIC_OUTPUT_COUNTER -- requirements
Module: stochastic_output_counter

Interface
REQ-001 SHALL take sizing from sys_defs.svh: SC_LEN, SC_LEN_LOG, INPUT_WIDTH, INPUT_WIDTH_LOG, KERNEL_WIDTH, each with no local default and each meaning the same as in the rest of the datapath.
REQ-002 SHALL define local parameter FIFO_DEPTH, default 4, as the number of completed results held pending drain.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising clock edge.
REQ-005 enable  input  1  the current bit pair is valid this cycle.
REQ-006 final_val_x  input  1  x stochastic bit from the last kernel row for the current (column, bit position).
REQ-007 final_val_y  input  1  y stochastic bit from the last kernel row for the current (column, bit position).
REQ-008 width_index  input  INPUT_WIDTH_LOG  input-image column index driven to the partial result buffer.
REQ-009 sc_count  input  SC_LEN_LOG  bit position within the stochastic stream.
REQ-010 out_valid  output  1  out_col, out_count_x and out_count_y hold a completed result.
REQ-011 out_ready  input  1  the consumer accepts the result this cycle.
REQ-012 out_col  output  INPUT_WIDTH_LOG  output column of the result.
REQ-013 out_count_x  output  SC_LEN_LOG+1  number of ones in the x stream.
REQ-014 out_count_y  output  SC_LEN_LOG+1  number of ones in the y stream.
REQ-015 overflow  output  1  sticky flag: a result was dropped because the FIFO was full.

Function
REQ-016 SHALL keep one x counter and one y counter per output column, each SC_LEN_LOG+1 bits wide, and SHALL index them by col = width_index - (KERNEL_WIDTH-1).
REQ-017 SHALL ignore every cycle with enable=1 and width_index < KERNEL_WIDTH-1: no counter update and no push.
REQ-018 On an accepted cycle (enable=1, valid col) with sc_count==0, SHALL load count_x[col]=final_val_x and count_y[col]=final_val_y, discarding prior contents.
REQ-019 On an accepted cycle with sc_count!=0, SHALL add final_val_x and final_val_y to the respective counters; counters SHALL NOT wrap, since the maximum value is SC_LEN.
REQ-020 On an accepted cycle with sc_count==SC_LEN-1, SHALL push {col, count + this cycle's bit} for x and y into the FIFO in that cycle.
REQ-021 Push-to-out_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-022 out_valid SHALL equal FIFO not-empty; outputs SHALL present the FIFO head.
REQ-023 A pop SHALL occur when out_valid && out_ready; results SHALL drain in push order.
REQ-024 While out_valid=1 and out_ready=0, the head outputs SHALL hold stable.
REQ-025 Simultaneous push and pop SHALL be legal at any occupancy, including full; occupancy SHALL be unchanged in that case.
REQ-026 A push while the FIFO is full with no pop SHALL drop the result and set overflow=1.
REQ-027 overflow SHALL stay 1 until reset.
REQ-028 Counter updates SHALL proceed regardless of FIFO state; the FIFO SHALL NOT backpressure the bit stream.
REQ-029 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 With reset=0 at a rising edge: counters=0, FIFO empty, out_valid=0, overflow=0.
REQ-031 While in reset, out_col=0, out_count_x=0 and out_count_y=0.
REQ-032 Reset asserted mid-stream SHALL discard all partial counts and pending results.
REQ-033 After reset, the first accepted sc_count==0 cycle SHALL start a fresh count.
REQ-034 enable and out_ready SHALL be ignored while reset=0.

Verification
REQ-035 SC_LEN=8, KERNEL_WIDTH=3, width_index=2, x bits 1,0,1,1,0,0,1,1, y all 1, out_ready=1 -> out_col=0, out_count_x=5, out_count_y=8, one cycle after sc_count=7.
REQ-036 enable=1 with width_index=1 (KERNEL_WIDTH=3), all bits 1 -> no counter change, out_valid stays 0.
REQ-037 Five columns complete with out_ready=0 -> four results held, fifth dropped, overflow=1; raising out_ready drains the four in column order.
REQ-038 FIFO full, push coinciding with out_ready=1 -> no drop, overflow stays 0, occupancy stays 4.
REQ-039 reset=0 asserted after sc_count=4 of a column, then the full stream replayed -> the count reflects only the replayed stream, and no stale result appears.
REQ-040 out_valid=1, out_ready held 0 for 3 cycles -> out_col, out_count_x and out_count_y unchanged across all 3 cycles.
